// File: rtl/proc_pkg.sv
// Shared types and widths for the instruction-fetch front end.
package proc_pkg;
   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      WAIT,
      FLUSH
   } fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer of DEPTH {pc, instr} entries; clear wins over push/pop.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   boot,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   clear,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge boot) begin
      if (boot) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: PC, single-outstanding imem requests, redirect and buffering.
// Optional FETCH_PERF_CNT_EN adds saturating stall_cnt / flush_cnt outputs.
//
// state | meaning
// IDLE  | one cycle after boot, no request
// FETCH | request imem at pc while buffer has room
// WAIT  | one request outstanding, response is pushed
// FLUSH | one request outstanding, response is stale and dropped
module fetch_sequencer
   import proc_pkg::*;
#(
   parameter logic [XLEN-1:0] BOOT_PC   = 32'h0000_0000,
   parameter int              BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            boot,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            br_taken,
   input  logic [XLEN-1:0] br_target,
   input  logic            dec_stall,
   output logic [XLEN-1:0] ir,
   output logic [XLEN-1:0] ir_pc,
   output logic            ir_valid
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]     stall_cnt,
   output logic [31:0]     flush_cnt
`endif
);
   localparam int CW = $clog2(BUF_DEPTH) + 1;

   fetch_state_t      state, state_nxt;
   logic [XLEN-1:0]   pc, pc_nxt, req_pc;
   logic              accept, outstanding;
   logic              push, pop, clear;
   logic              fifo_full, fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic [2*XLEN-1:0] fifo_dout;

   assign accept    = imem_req && imem_ready;
   assign pop       = ir_valid && !dec_stall && !br_taken;
   assign imem_addr = pc;
   assign ir_valid  = !fifo_empty;
   assign ir        = fifo_dout[XLEN-1:0];
   assign ir_pc     = fifo_dout[2*XLEN-1:XLEN];

   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      imem_req    = 1'b0;
      push        = 1'b0;
      clear       = 1'b0;
      outstanding = 1'b0;
      case (state)
         IDLE:  state_nxt = FETCH;
         FETCH: begin
            // nothing is outstanding in FETCH, so occupancy alone decides room
            imem_req = (fifo_count < CW'(BUF_DEPTH));
            if (imem_req && imem_ready) begin
               state_nxt = WAIT;
               pc_nxt    = pc + XLEN'(INSTR_BYTES);
            end
         end
         WAIT: if (imem_rvalid) begin
            push      = !fifo_full || pop;
            state_nxt = FETCH;
         end
         FLUSH: if (imem_rvalid) state_nxt = FETCH;
         default: state_nxt = IDLE;
      endcase
      if (br_taken) begin
         clear       = 1'b1;
         push        = 1'b0;
         pc_nxt      = br_target & ~XLEN'(3);
         outstanding = (state == FETCH && imem_req && imem_ready) ||
                       ((state == WAIT || state == FLUSH) && !imem_rvalid);
         state_nxt   = outstanding ? FLUSH : FETCH;
      end
   end

   always_ff @(posedge clk or posedge boot) begin
      if (boot) begin
         state  <= IDLE;
         pc     <= BOOT_PC;
         req_pc <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         if (accept) req_pc <= pc;
      end
   end

   fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(2*XLEN)) u_fifo (
      .clk   (clk),
      .boot  (boot),
      .push  (push),
      .pop   (pop),
      .clear (clear),
      .din   ({req_pc, imem_rdata}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or posedge boot) begin
      if (boot) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (ir_valid && dec_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
         if (br_taken && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; a second instance boots at 0xFFFF_FFFC for PC wrap.
module tb_fetch_sequencer;
   logic        clk = 1'b0;
   logic        boot, imem_ready, imem_rvalid, br_taken, dec_stall;
   logic [31:0] imem_rdata, br_target;
   logic        imem_req, ir_valid, imem_req_w, ir_valid_w;
   logic [31:0] imem_addr, ir, ir_pc, imem_addr_w, ir_w, ir_pc_w;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt, stall_cnt_w, flush_cnt_w;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fetch_sequencer #(.BOOT_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
      .clk(clk), .boot(boot), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .br_taken(br_taken), .br_target(br_target), .dec_stall(dec_stall),
      .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid)
`ifdef FETCH_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   fetch_sequencer #(.BOOT_PC(32'hFFFF_FFFC), .BUF_DEPTH(2)) dut_wrap (
      .clk(clk), .boot(boot), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
      .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .br_taken(br_taken), .br_target(br_target), .dec_stall(dec_stall),
      .ir(ir_w), .ir_pc(ir_pc_w), .ir_valid(ir_valid_w)
`ifdef FETCH_PERF_CNT_EN
      , .stall_cnt(stall_cnt_w), .flush_cnt(flush_cnt_w)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] word(input logic [31:0] a);
      return a ^ 32'hC3C3_5A5A;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_boot();
      boot = 1'b1;
      tick();
      tick();
      boot = 1'b0;
   endtask

   initial begin
      boot = 1'b1; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
      br_taken = 1'b0; br_target = '0; dec_stall = 1'b0;
      tick();
      tick();
      check("boot_req", 32'(imem_req), 32'd0);
      check("boot_irv", 32'(ir_valid), 32'd0);
      check("boot_ir", ir, 32'd0);
      check("boot_irpc", ir_pc, 32'd0);
      check("boot_addr", imem_addr, 32'h0);
      check("boot_addr_wrap", imem_addr_w, 32'hFFFF_FFFC);

      // 1: straight-line fetch
      boot = 1'b0;
      check("idle_req", 32'(imem_req), 32'd0);
      tick();
      check("s1_req", 32'(imem_req), 32'd1);
      check("s1_addr0", imem_addr, 32'h0);
      check("s5_addr0", imem_addr_w, 32'hFFFF_FFFC);
      tick();
      check("s1_wait_req", 32'(imem_req), 32'd0);
      imem_rvalid = 1'b1; imem_rdata = word(32'h0);
      tick();
      imem_rvalid = 1'b0;
      check("s1_irv", 32'(ir_valid), 32'd1);
      check("s1_irpc", ir_pc, 32'h0);
      check("s1_ir", ir, word(32'h0));
      check("s1_addr1", imem_addr, 32'h4);
      check("s5_addr1", imem_addr_w, 32'h0);
      tick();
      imem_rvalid = 1'b1; imem_rdata = word(32'h4);
      tick();
      imem_rvalid = 1'b0;
      check("s1_addr2", imem_addr, 32'h8);
      check("s1_irpc2", ir_pc, 32'h4);

      // 2: decoder backpressure
      dec_stall = 1'b1;
      do_boot();
      tick();
      tick();
      imem_rvalid = 1'b1; imem_rdata = word(32'h0);
      tick();
      imem_rvalid = 1'b0;
      tick();
      imem_rvalid = 1'b1; imem_rdata = word(32'h4);
      tick();
      imem_rvalid = 1'b0;
      check("s2_req_drop", 32'(imem_req), 32'd0);
      check("s2_irpc", ir_pc, 32'h0);
      check("s2_ir", ir, word(32'h0));
      tick();
      check("s2_req_hold", 32'(imem_req), 32'd0);
      check("s2_irv", 32'(ir_valid), 32'd1);
`ifdef FETCH_PERF_CNT_EN
      check("s2_stall_cnt", stall_cnt, 32'd3);
`endif
      dec_stall = 1'b0;
      tick();
      check("s2_pop_irpc", ir_pc, 32'h4);
      check("s2_resume_req", 32'(imem_req), 32'd1);
      check("s2_resume_addr", imem_addr, 32'h8);
      tick();
      check("s2_drain_irv", 32'(ir_valid), 32'd0);

      // 3: redirect while waiting
      br_taken = 1'b1; br_target = 32'h103;
      tick();
      br_taken = 1'b0;
      check("s3_flush_req", 32'(imem_req), 32'd0);
      check("s3_flush_irv", 32'(ir_valid), 32'd0);
      imem_rvalid = 1'b1; imem_rdata = word(32'h8);
      tick();
      imem_rvalid = 1'b0;
      check("s3_stale_irv", 32'(ir_valid), 32'd0);
      check("s3_addr", imem_addr, 32'h100);
      check("s3_req", 32'(imem_req), 32'd1);
      tick();
      check("s3_wait_irv", 32'(ir_valid), 32'd0);
      imem_rvalid = 1'b1; imem_rdata = word(32'h100);
      tick();
      imem_rvalid = 1'b0;
      check("s3_irv", 32'(ir_valid), 32'd1);
      check("s3_irpc", ir_pc, 32'h100);
      check("s3_ir", ir, word(32'h100));
`ifdef FETCH_PERF_CNT_EN
      check("s3_flush_cnt", flush_cnt, 32'd1);
`endif

      // 4: redirect same cycle as rvalid and pop
      dec_stall = 1'b1;
      tick();
      check("s4_pre_irpc", ir_pc, 32'h100);
      imem_rvalid = 1'b1; imem_rdata = word(32'h104);
      dec_stall = 1'b0; br_taken = 1'b1; br_target = 32'h200;
      tick();
      imem_rvalid = 1'b0; br_taken = 1'b0;
      check("s4_irv", 32'(ir_valid), 32'd0);
      check("s4_addr", imem_addr, 32'h200);
      check("s4_req", 32'(imem_req), 32'd1);
      tick();
      check("s4_wait_irv", 32'(ir_valid), 32'd0);
      imem_rvalid = 1'b1; imem_rdata = word(32'h200);
      tick();
      imem_rvalid = 1'b0;
      check("s4_irpc", ir_pc, 32'h200);
`ifdef FETCH_PERF_CNT_EN
      check("s4_flush_cnt", flush_cnt, 32'd2);
`endif

      // 6: boot during WAIT, late response ignored
      tick();
      boot = 1'b1;
      #1;
      check("s6_boot_req", 32'(imem_req), 32'd0);
      check("s6_boot_irv", 32'(ir_valid), 32'd0);
      check("s6_boot_addr", imem_addr, 32'h0);
      tick();
      boot = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = word(32'h204);
      tick();
      imem_rvalid = 1'b0;
      check("s6_restart_addr", imem_addr, 32'h0);
      check("s6_restart_req", 32'(imem_req), 32'd1);
      check("s6_irv", 32'(ir_valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
      check("s6_flush_cnt", flush_cnt, 32'd0);
      check("s6_stall_cnt", stall_cnt, 32'd0);
`endif
      imem_ready = 1'b0;
      tick();
      check("s6_hold_addr", imem_addr, 32'h0);
      check("s6_hold_req", 32'(imem_req), 32'd1);
      imem_ready = 1'b1;
      tick();
      check("s6_wait_req", 32'(imem_req), 32'd0);
      imem_rvalid = 1'b1; imem_rdata = word(32'h0);
      tick();
      imem_rvalid = 1'b0;
      check("s6_irv_final", 32'(ir_valid), 32'd1);
      check("s6_irpc", ir_pc, 32'h0);
      check("s6_ir", ir, word(32'h0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
